// File: rtl/bldc_pkg.sv
// Shared encodings and helpers for the six-step BLDC commutation sequencer.
package bldc_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StDead  = 2'd2,
        StFault = 2'd3
    } state_e;

    localparam int unsigned GateAh = 5;
    localparam int unsigned GateAl = 4;
    localparam int unsigned GateBh = 3;
    localparam int unsigned GateBl = 2;
    localparam int unsigned GateCh = 1;
    localparam int unsigned GateCl = 0;

    // Returns {valid, sector}; 000 and 111 are not legal Hall states.
    function automatic logic [3:0] hall_decode(input logic [2:0] h);
        logic [3:0] r;
        case (h)
            3'b101:  r = 4'b1_000;
            3'b100:  r = 4'b1_001;
            3'b110:  r = 4'b1_010;
            3'b010:  r = 4'b1_011;
            3'b011:  r = 4'b1_100;
            3'b001:  r = 4'b1_101;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] fwd_pattern(input logic [2:0] sector);
        logic [5:0] g;
        g = '0;
        case (sector)
            3'd0: begin g[GateAh] = 1'b1; g[GateBl] = 1'b1; end
            3'd1: begin g[GateAh] = 1'b1; g[GateCl] = 1'b1; end
            3'd2: begin g[GateBh] = 1'b1; g[GateCl] = 1'b1; end
            3'd3: begin g[GateBh] = 1'b1; g[GateAl] = 1'b1; end
            3'd4: begin g[GateCh] = 1'b1; g[GateAl] = 1'b1; end
            3'd5: begin g[GateCh] = 1'b1; g[GateBl] = 1'b1; end
            default: g = '0;
        endcase
        return g;
    endfunction

    // Reverse drive uses the same phase pair with high and low sides exchanged.
    function automatic logic [5:0] swap_sides(input logic [5:0] g);
        return {g[GateAl], g[GateAh], g[GateBl], g[GateBh], g[GateCl], g[GateCh]};
    endfunction

    // Returns {is_forward_step, is_reverse_step} modulo 6.
    function automatic logic [1:0] step_dir(input logic [2:0] old_sec, input logic [2:0] new_sec);
        logic [2:0] nxt;
        logic [2:0] prv;
        nxt = (old_sec == 3'd5) ? 3'd0 : old_sec + 3'd1;
        prv = (old_sec == 3'd0) ? 3'd5 : old_sec - 3'd1;
        return {new_sec == nxt, new_sec == prv};
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Two-flop synchroniser plus FILT_CYC-sample debounce for the Hall bus;
// h_chg_o pulses for one cycle when the accepted code changes.
module hall_input_filter #(
    parameter int unsigned FILT_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] h_i,
    output logic [2:0] h_acc_o,
    output logic       h_chg_o
);

    localparam int unsigned CntW = $clog2(FILT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYC);

    logic [2:0]      sync1_q, sync2_q, cand_q;
    logic [2:0]      h_acc_q, h_acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            chg_q, chg_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cand_q  <= 3'b000;
            h_acc_q <= 3'b000;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= h_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            h_acc_q <= h_acc_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        if (sync2_q != cand_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        h_acc_d = h_acc_q;
        chg_d   = 1'b0;
        // Accept on the edge that completes the run of identical samples.
        if ((cnt_d == CntMax) && (sync2_q != h_acc_q)) begin
            h_acc_d = sync2_q;
            chg_d   = 1'b1;
        end
    end

    assign h_acc_o = h_acc_q;
    assign h_chg_o = chg_q;

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer with dead time and fault supervision.
// Define HALL_DIR_CHECK_EN to also fault on a valid step against DIR.
module bldc_commutation_ctrl
    import bldc_pkg::*;
#(
    parameter int unsigned DEADTIME_CYC = 4,
    parameter int unsigned FILT_CYC     = 2,
    parameter int unsigned STALL_CYC    = 200
) (
    input  logic       OUT_CLK,
    input  logic       RST,
    input  logic [2:0] H,
    input  logic       EN,
    input  logic       DIR,
    output logic [5:0] GATE,
    output logic       FAULT,
    output logic [1:0] STATE,
    output logic [2:0] SECTOR
);

    localparam int unsigned DeadW  = $clog2(DEADTIME_CYC + 1);
    localparam int unsigned StallW = (STALL_CYC > 0) ? $clog2(STALL_CYC + 1) : 1;
    localparam logic [DeadW-1:0]  DeadLoad = DeadW'(DEADTIME_CYC);
    localparam logic [StallW-1:0] StallMax = StallW'(STALL_CYC);

    state_e            state_q, state_d;
    logic [2:0]        sector_q, sector_d;
    logic [DeadW-1:0]  dead_q, dead_d;
    logic [StallW-1:0] stall_q, stall_d, stall_inc;
    logic              dir_q;

    logic [2:0] h_acc;
    logic       h_chg;
    logic [3:0] dec;
    logic       h_valid;
    logic [2:0] h_sec;
    logic [1:0] steps;
    logic       step_ok;
    logic       stall_hit;
    logic [5:0] pattern;

    hall_input_filter #(
        .FILT_CYC(FILT_CYC)
    ) u_filter (
        .clk_i  (OUT_CLK),
        .rst_i  (RST),
        .h_i    (H),
        .h_acc_o(h_acc),
        .h_chg_o(h_chg)
    );

    assign dec     = hall_decode(h_acc);
    assign h_valid = dec[3];
    assign h_sec   = dec[2:0];
    assign steps   = step_dir(sector_q, h_sec);

`ifdef HALL_DIR_CHECK_EN
    assign step_ok = DIR ? steps[0] : steps[1];
`else
    assign step_ok = |steps;
`endif

    assign stall_inc = (stall_q >= StallMax) ? stall_q : stall_q + StallW'(1);
    assign stall_hit = (STALL_CYC != 0) && (stall_inc >= StallMax);

    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            sector_q <= 3'd0;
            dead_q   <= '0;
            stall_q  <= '0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            dead_q   <= dead_d;
            stall_q  <= stall_d;
            dir_q    <= DIR;
        end
    end

    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        dead_d   = dead_q;
        stall_d  = stall_q;
        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (EN && h_valid) begin
                    sector_d = h_sec;
                    dead_d   = DeadLoad;
                    state_d  = StDead;
                end
            end
            StDead, StDrive: begin
                stall_d = stall_inc;
                // A sector change on the same edge as a stall takes precedence.
                if (h_chg && !h_valid) begin
                    state_d = StFault;
                end else if (h_chg && (h_sec != sector_q)) begin
                    if (step_ok) begin
                        sector_d = h_sec;
                        dead_d   = DeadLoad;
                        stall_d  = '0;
                        state_d  = StDead;
                    end else begin
                        state_d = StFault;
                    end
                end else if (stall_hit) begin
                    state_d = StFault;
                end else if (state_q == StDead) begin
                    if (dead_q <= DeadW'(1)) begin
                        state_d = StDrive;
                    end else begin
                        dead_d = dead_q - DeadW'(1);
                    end
                end else if (DIR != dir_q) begin
                    dead_d  = DeadLoad;
                    state_d = StDead;
                end
            end
            StFault: begin
                stall_d = '0;
            end
            default: state_d = StIdle;
        endcase
        if (!EN) begin
            state_d = StIdle;
            stall_d = '0;
        end
    end

    always_comb begin
        pattern = fwd_pattern(sector_q);
        GATE    = '0;
        if (state_q == StDrive) begin
            GATE = dir_q ? swap_sides(pattern) : pattern;
        end
    end

    assign FAULT  = (state_q == StFault);
    assign STATE  = state_q;
    assign SECTOR = sector_q;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Scoreboard bench for bldc_commutation_ctrl: stimulus queues timed expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_bldc_commutation_ctrl;

    logic       OUT_CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] H = 3'b101;
    logic       EN = 1'b1;
    logic       DIR = 1'b0;
    logic [5:0] GATE;
    logic       FAULT;
    logic [1:0] STATE;
    logic [2:0] SECTOR;

    bldc_commutation_ctrl dut (
        .OUT_CLK(OUT_CLK),
        .RST    (RST),
        .H      (H),
        .EN     (EN),
        .DIR    (DIR),
        .GATE   (GATE),
        .FAULT  (FAULT),
        .STATE  (STATE),
        .SECTOR (SECTOR)
    );

    always #5 OUT_CLK = ~OUT_CLK;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] st;
        logic [5:0] g;
        logic [2:0] sec;
    } exp_t;

    localparam logic [2:0] HCODE [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    localparam logic [5:0] FWD   [6] = '{6'b100100, 6'b100001, 6'b001001,
                                         6'b011000, 6'b010010, 6'b000110};
    localparam logic [5:0] REV   [6] = '{6'b011000, 6'b010010, 6'b000110,
                                         6'b100100, 6'b100001, 6'b001001};

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] cur_st;
    logic [5:0] cur_gate;
    logic [2:0] cur_sec;
    int         last_chg;

    always @(posedge OUT_CLK) cyc <= cyc + 1;

    always @(negedge OUT_CLK) begin : monitor
        int i;
        logic f;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                f = (sb[i].st == 2'd3);
                checks++;
                if ({STATE, GATE, FAULT, SECTOR} !== {sb[i].st, sb[i].g, f, sb[i].sec}) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got state=%0d gate=%b fault=%b sector=%0d, want state=%0d gate=%b fault=%b sector=%0d",
                             sb[i].name, cyc, STATE, GATE, FAULT, SECTOR,
                             sb[i].st, sb[i].g, f, sb[i].sec);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cyc %0d was never sampled (now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge OUT_CLK);
        #1;
    endtask

    task automatic expect_at(input int at, input string nm, input logic [1:0] st,
                             input logic [5:0] g, input logic [2:0] sec);
        exp_t e;
        e.cyc = at; e.name = nm; e.st = st; e.g = g; e.sec = sec;
        sb.push_back(e);
    endtask

    // Apply a Hall code for sector s and expect dead time then the drive pattern.
    task automatic step(input int s, input logic dir, input string nm);
        int c;
        logic [5:0] pat;
        pat = dir ? REV[s] : FWD[s];
        c = cyc;
        H = HCODE[s];
        expect_at(c + 4, {nm, "_pre"}, cur_st, cur_gate, cur_sec);
        for (int k = 5; k <= 8; k++) expect_at(c + k, {nm, "_dead"}, 2'd2, 6'b0, 3'(s));
        expect_at(c + 9, {nm, "_drive"}, 2'd1, pat, 3'(s));
        cur_st = 2'd1; cur_gate = pat; cur_sec = 3'(s); last_chg = c;
        tick(10);
    endtask

    task automatic fault_then_clear(input string nm);
        for (int k = 1; k <= 5; k++) expect_at(cyc + k, {nm, "_hold"}, 2'd3, 6'b0, 3'd0);
        tick(5);
        EN = 1'b0;
        expect_at(cyc + 1, {nm, "_clear"}, 2'd0, 6'b0, 3'd0);
        tick(2);
    endtask

    // From IDLE with h_acc already 101: EN high gives dead time then sector-0 drive.
    task automatic restart(input logic [5:0] pat, input string nm);
        EN = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(cyc + k, {nm, "_dead"}, 2'd2, 6'b0, 3'd0);
        expect_at(cyc + 5, {nm, "_drive"}, 2'd1, pat, 3'd0);
        cur_st = 2'd1; cur_gate = pat; cur_sec = 3'd0;
        tick(6);
    endtask

    initial begin
        int c;
        int t;
        // Reset values held while RST is high.
        tick(1);
        expect_at(cyc + 1, "reset_a", 2'd0, 6'b0, 3'd0);
        expect_at(cyc + 2, "reset_b", 2'd0, 6'b0, 3'd0);
        tick(3);

        // Test 1: release with H=101, EN=1.
        cur_st = 2'd0; cur_gate = 6'b0; cur_sec = 3'd0;
        RST = 1'b0;
        step(0, 1'b0, "start");

        // Test 2: full forward rotation.
        for (int s = 1; s <= 5; s++) step(s, 1'b0, "fwd");
        step(0, 1'b0, "fwd_wrap");

        // Test 4: one-cycle glitch is ignored, then stall watchdog fires.
        c = cyc;
        H = 3'b100;
        tick(1);
        H = 3'b101;
        for (int k = 1; k <= 10; k++) expect_at(c + k, "glitch", 2'd1, FWD[0], 3'd0);
        expect_at(last_chg + 204, "stall_pre", 2'd1, FWD[0], 3'd0);
        expect_at(last_chg + 205, "stall_fault", 2'd3, 6'b0, 3'd0);
        tick(last_chg + 206 - cyc);
        fault_then_clear("stall");
        restart(FWD[0], "after_stall");

        // Test 3a: skipped sector 0 -> 3.
        c = cyc;
        H = 3'b010;
        expect_at(c + 4, "skip_pre", 2'd1, FWD[0], 3'd0);
        expect_at(c + 5, "skip_fault", 2'd3, 6'b0, 3'd0);
        tick(6);
        fault_then_clear("skip");
        H = 3'b101;
        tick(6);
        restart(FWD[0], "after_skip");

        // Test 3b: invalid code 111, then EN=1 with invalid code stays IDLE.
        c = cyc;
        H = 3'b111;
        expect_at(c + 4, "inval_pre", 2'd1, FWD[0], 3'd0);
        expect_at(c + 5, "inval_fault", 2'd3, 6'b0, 3'd0);
        tick(6);
        fault_then_clear("inval");
        EN = 1'b1;
        for (int k = 1; k <= 3; k++) expect_at(cyc + k, "idle_invalid", 2'd0, 6'b0, 3'd0);
        tick(4);
        cur_st = 2'd0; cur_gate = 6'b0; cur_sec = 3'd0;
        step(0, 1'b0, "from_idle");

        // Test 5: DIR toggle in DRIVE inserts dead time, then reverse pattern.
        DIR = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(cyc + k, "dir_dead", 2'd2, 6'b0, 3'd0);
        expect_at(cyc + 5, "dir_drive", 2'd1, REV[0], 3'd0);
        cur_gate = REV[0];
        tick(6);
`ifdef HALL_DIR_CHECK_EN
        c = cyc;
        H = HCODE[1];
        expect_at(c + 4, "wrongdir_pre", 2'd1, REV[0], 3'd0);
        expect_at(c + 5, "wrongdir_fault", 2'd3, 6'b0, 3'd0);
        tick(6);
        EN = 1'b0;
        H = 3'b101;
        tick(6);
        restart(REV[0], "after_wrongdir");
`else
        step(1, 1'b1, "rev_a");
        step(0, 1'b1, "rev_b");
`endif
        step(5, 1'b1, "rev_c");

        // Test 6: asynchronous reset between edges mid-DRIVE.
        expect_at(cyc, "pre_rst", 2'd1, REV[5], 3'd5);
        tick(1);
        #2;
        RST = 1'b1;
        expect_at(cyc, "rst_async", 2'd0, 6'b0, 3'd0);
        expect_at(cyc + 1, "rst_hold", 2'd0, 6'b0, 3'd0);

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            tick(1);
            t++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bldc_commutation_ctrl.md
Name: bldc_commutation_ctrl

Overview:
- Six-step BLDC commutation sequencer driven by the 3-bit Hall sensor bus. It sits beside the Hall speed encoder on the same divided clock.
- Synchronises and debounces H, decodes the rotor sector, validates sector transitions, and sequences gate enables with dead time on every change.
- Supervises for illegal Hall codes, skipped sectors and stall, and latches a sticky fault that drops all gates.

Parameters:
- DEADTIME_CYC, default 4: OUT_CLK cycles with all gates off between patterns; must be >= 1.
- FILT_CYC, default 2: consecutive equal synchronised samples before a Hall code is accepted; must be >= 1.
- STALL_CYC, default 200: cycles without an accepted sector change before a stall fault; 0 disables the watchdog.

Ports:
- OUT_CLK  in  1  block clock (divided clock).
- RST  in  1  asynchronous, active-high reset.
- H  in  3  raw Hall inputs {Ha,Hb,Hc}; asynchronous.
- EN  in  1  run enable; low forces IDLE and clears a fault.
- DIR  in  1  0 = forward, 1 = reverse.
- GATE  out  6  {AH,AL,BH,BL,CH,CL}; 1 = switch on.
- FAULT  out  1  sticky fault flag.
- STATE  out  2  0 IDLE, 1 DRIVE, 2 DEAD, 3 FAULT.
- SECTOR  out  3  latched sector, 0..5.

Behaviour:
- Reset is RST, asynchronous, active-high; the clock is OUT_CLK. While RST is high: GATE=0, FAULT=0, STATE=IDLE, SECTOR=0, sync/filter registers=3'b000, all counters=0. GATE must drop the moment RST asserts, mid-operation included.
- Input path: 2-flop synchroniser, then a filter. The accepted code h_acc updates only after FILT_CYC consecutive identical synchronised samples. A pulse shorter than FILT_CYC cycles is ignored.
- Latency: from a stable H change to the GATE response is 2 + FILT_CYC + 1 edges (5 with defaults).
- Sector decode of h_acc: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 are invalid.
- Forward drive pattern per sector: 0 AH+BL, 1 AH+CL, 2 BH+CL, 3 BH+AL, 4 CH+AL, 5 CH+BL.
- Reverse drive pattern: same phase pair with high and low swapped (sector 0 → BH+AL).
- GATE never has both switches of one phase on; GATE=0 in IDLE, DEAD and FAULT.
- Adjacent step = new sector = old ±1 mod 6.
- FSM transitions, in priority order: EN=0 > fault conditions > other transitions.
  - IDLE:
    - EN=1 and h_acc valid → latch sector, load the dead counter, go to DEAD.
    - EN=1 and h_acc invalid → stay in IDLE, no fault.
  - DEAD:
    - Count DEADTIME_CYC cycles, then go to DRIVE.
    - Adjacent sector change during DEAD → latch the new sector and restart the dead counter.
    - Non-adjacent change or invalid code → FAULT.
  - DRIVE:
    - Output the pattern for (SECTOR, DIR).
    - Adjacent change → latch the new sector and go to DEAD.
    - DIR toggle → go to DEAD, sector unchanged.
    - Non-adjacent or invalid code → FAULT.
  - FAULT: FAULT=1, stays with EN=1; EN=0 → IDLE with FAULT cleared the same edge.
  - Any state except IDLE: EN=0 → IDLE.
- Stall counter:
  - Saturating, width clog2(STALL_CYC+1).
  - Counts in DRIVE and DEAD; cleared on an accepted sector change and on leaving IDLE.
  - Reaching STALL_CYC → FAULT.
- Simultaneous stall and sector change on the same edge: the sector change wins.

Optional Feature:
- Macro: HALL_DIR_CHECK_EN.
- Defined: an accepted step must match DIR (forward +1 mod 6, reverse −1 mod 6); a valid step in the wrong direction → FAULT.
- Undefined: either adjacent step is accepted.

Decomposition:
- Package bldc_pkg holds:
  - state encoding constants;
  - GATE bit indices;
  - Hall-to-sector decode function;
  - forward pattern table;
  - adjacency function.
- One sub-module, hall_input_filter: the synchroniser plus the FILT_CYC debounce; outputs h_acc and a 1-cycle h_chg strobe.

Test Plan:
1. RST pulse, EN=1, H=101 → STATE 2 for 4 cycles, then STATE 1, GATE=6'b100100, SECTOR=0.
2. In DRIVE with sector 0, H→100 → GATE=0 for 4 cycles, then GATE=6'b100001, SECTOR=1; full forward rotation returns to sector 0 with no FAULT.
3. Skip fault: H 101→010 → FAULT=1, STATE=3, GATE=0. Invalid code: separately, H 101→111 gives the same response. Hold EN=1 5 cycles → unchanged; EN=0 → STATE=0, FAULT=0.
4. 1-cycle H glitch in DRIVE → GATE unchanged. Hold H static → FAULT asserts exactly 200 cycles after the last accepted change.
5. DIR 0→1 in sector 0 DRIVE → 4 dead cycles, then GATE=6'b011000. With HALL_DIR_CHECK_EN defined, step 0→1 while DIR=1 → FAULT.
6. RST asserted mid-DRIVE, between clock edges → GATE=0 immediately, all outputs at reset values.
